// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: FSM states, opcodes, special sub-codes and
// instruction field positions.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StWb,
    StHalt
  } state_e;

  localparam int unsigned InstrW = 9;

  localparam int unsigned OpcHi = 8;
  localparam int unsigned OpcLo = 6;
  localparam int unsigned RdHi  = 5;
  localparam int unsigned RdLo  = 4;
  localparam int unsigned RsHi  = 3;
  localparam int unsigned RsLo  = 2;
  localparam int unsigned RtHi  = 1;
  localparam int unsigned RtLo  = 0;
  localparam int unsigned SubHi = 5;
  localparam int unsigned SubLo = 4;
  localparam int unsigned ImmHi = 3;
  localparam int unsigned ImmLo = 0;

  localparam logic [2:0] OpInc     = 3'b000;
  localparam logic [2:0] OpNot     = 3'b001;
  localparam logic [2:0] OpXor     = 3'b010;
  localparam logic [2:0] OpDec     = 3'b011;
  localparam logic [2:0] OpAdd     = 3'b100;
  localparam logic [2:0] OpSub     = 3'b101;
  localparam logic [2:0] OpAnd     = 3'b110;
  localparam logic [2:0] OpSpecial = 3'b111;

  localparam logic [1:0] SubBz   = 2'b00;
  localparam logic [1:0] SubLi   = 2'b01;
  localparam logic [1:0] SubHalt = 2'b10;
  localparam logic [1:0] SubNop  = 2'b11;

  function automatic logic is_alu_op(logic [2:0] op);
    case (op)
      OpInc, OpNot, OpXor, OpDec, OpAdd, OpSub, OpAnd: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// 2**AW x DW register file: two asynchronous read ports, one synchronous write port.
module alu_sequencer_regfile #(
  parameter int unsigned AW = 2,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem [2**AW];

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer driving an external ALU: FETCH -> EXEC -> WB per
// instruction, with branch-on-zero, load-immediate, halt and nop specials.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned AW = 2,
  parameter int unsigned DW = 8,
  parameter int unsigned PW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              instr_req,
  output logic [PW-1:0]     pc,
  input  logic              instr_valid,
  input  logic [InstrW-1:0] instr_i,
  output logic [2:0]        alu_op,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  input  logic [DW-1:0]     alu_result,
  input  logic              alu_zero,
  output logic              busy,
  output logic              done
);

  state_e              state_q;
  logic [InstrW-1:0]   ir_q;
  logic                zflag_q;
  logic [DW-1:0]       res_q;
  logic                zero_q;

  logic [2:0]          f_op;
  logic [2:0]          ir_op;
  logic [1:0]          ir_sub;
  logic                is_alu, is_li, is_bz, is_halt;
  logic [PW-1:0]       bz_off;
  logic [DW-1:0]       rdata_a, rdata_b;
  logic                rf_we;
  logic [AW-1:0]       rf_waddr;
  logic [DW-1:0]       rf_wdata;

  assign f_op    = instr_i[OpcHi:OpcLo];
  assign ir_op   = ir_q[OpcHi:OpcLo];
  assign ir_sub  = ir_q[SubHi:SubLo];
  assign is_alu  = is_alu_op(ir_op);
  assign is_li   = (ir_op == OpSpecial) && (ir_sub == SubLi);
  assign is_bz   = (ir_op == OpSpecial) && (ir_sub == SubBz);
  assign is_halt = (ir_op == OpSpecial) && (ir_sub == SubHalt);
  assign bz_off  = {{(PW-4){ir_q[ImmHi]}}, ir_q[ImmHi:ImmLo]};

  // Operands are read while the instruction is on the bus so they can be registered
  // straight onto the ALU inputs for the EXEC cycle.
  assign rf_we    = (state_q == StWb) && (is_alu || is_li);
  assign rf_waddr = is_alu ? AW'(ir_q[RdHi:RdLo]) : '0;
  assign rf_wdata = is_alu ? res_q : DW'(ir_q[ImmHi:ImmLo]);

  alu_sequencer_regfile #(
    .AW(AW),
    .DW(DW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (AW'(instr_i[RsHi:RsLo])),
    .rdata_a (rdata_a),
    .raddr_b (AW'(instr_i[RtHi:RtLo])),
    .rdata_b (rdata_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pc        <= '0;
      ir_q      <= '0;
      zflag_q   <= 1'b0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      instr_req <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      unique case (state_q)
        StIdle, StHalt: begin
          if (start) begin
            state_q   <= StFetch;
            pc        <= '0;
            zflag_q   <= 1'b0;
            instr_req <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        StFetch: begin
          if (instr_valid) begin
            ir_q      <= instr_i;
            state_q   <= StExec;
            instr_req <= 1'b0;
            if (is_alu_op(f_op)) begin
              alu_op <= f_op;
              alu_a  <= rdata_a;
              alu_b  <= rdata_b;
            end
          end
        end
        StExec: begin
          res_q   <= alu_result;
          zero_q  <= alu_zero;
          alu_op  <= '0;
          alu_a   <= '0;
          alu_b   <= '0;
          state_q <= StWb;
        end
        StWb: begin
          if (is_alu) zflag_q <= zero_q;
          if (is_halt) begin
            state_q <= StHalt;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_q   <= StFetch;
            instr_req <= 1'b1;
            pc        <= (is_bz && zflag_q) ? pc + bz_off : pc + PW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, instruction-level reference model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       instr_req;
  logic [7:0] pc;
  logic       instr_valid = 1'b0;
  logic [8:0] instr_i = '0;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       alu_zero;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  // Reference machine state.
  logic [7:0] m_reg [4];
  logic [7:0] m_pc;
  logic       m_z;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'b000:  return a + 8'd1;
      3'b001:  return ~a;
      3'b010:  return a ^ b;
      3'b011:  return a - 8'd1;
      3'b100:  return a + b;
      3'b101:  return a - b;
      3'b110:  return a & b;
      default: return 8'd0;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == 8'd0);

  alu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .instr_req   (instr_req),
    .pc          (pc),
    .instr_valid (instr_valid),
    .instr_i     (instr_i),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .busy        (busy),
    .done        (done)
  );

  function automatic logic [8:0] mk_alu(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [1:0] rt);
    return {op, rd, rs, rt};
  endfunction

  function automatic logic [8:0] mk_sp(input logic [1:0] sub, input logic [3:0] imm);
    return {3'b111, sub, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'd0;
    m_pc = 8'd0;
    m_z  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc = 8'd0;
    m_z  = 1'b0;
  endtask

  // Drives one fetch handshake after `waits` stall cycles and follows the instruction
  // through EXEC and WB, updating the reference model at instruction granularity.
  task automatic run_instr(input logic [8:0] ins, input int waits, input bit abort_wb);
    logic [2:0] op;
    logic [1:0] rd, rs, rt, sub;
    logic [7:0] res;
    int n;
    op  = ins[8:6];
    rd  = ins[5:4];
    rs  = ins[3:2];
    rt  = ins[1:0];
    sub = ins[5:4];
    n = 0;
    while (instr_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (instr_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_timeout: instr_req=%b required=1", instr_req);
      return;
    end
    checks++;
    if (pc !== m_pc) begin
      errors++;
      $display("FAIL fetch_pc: pc=%0d required=%0d", pc, m_pc);
    end
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      checks++;
      if (instr_req !== 1'b1 || pc !== m_pc || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL stall: req=%b pc=%0d busy=%b done=%b required 1 %0d 1 0",
                 instr_req, pc, busy, done, m_pc);
      end
    end
    instr_i = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_i = 9'($urandom);
    checks++;
    if (op != 3'b111) begin
      if (alu_op !== op || alu_a !== m_reg[rs] || alu_b !== m_reg[rt]) begin
        errors++;
        $display("FAIL exec_alu: op=%b a=%0d b=%0d required op=%b a=%0d b=%0d",
                 alu_op, alu_a, alu_b, op, m_reg[rs], m_reg[rt]);
      end
    end else if (alu_op !== 3'd0 || alu_a !== 8'd0 || alu_b !== 8'd0) begin
      errors++;
      $display("FAIL exec_special: op=%b a=%0d b=%0d required all 0", alu_op, alu_a, alu_b);
    end
    res = alu_ref(op, m_reg[rs], m_reg[rt]);
    @(negedge clk);
    if (abort_wb) begin
      rst = 1'b1;
      #1;
      model_reset();
      return;
    end
    checks++;
    if (alu_op !== 3'd0 || alu_a !== 8'd0 || alu_b !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wb_outputs: op=%b a=%0d b=%0d busy=%b required 0 0 0 1",
               alu_op, alu_a, alu_b, busy);
    end
    if (op != 3'b111) begin
      m_reg[rd] = res;
      m_z = (res == 8'd0);
      m_pc = m_pc + 8'd1;
    end else begin
      case (sub)
        2'b00:   m_pc = m_z ? m_pc + {{4{ins[3]}}, ins[3:0]} : m_pc + 8'd1;
        2'b01: begin
          m_reg[0] = {4'd0, ins[3:0]};
          m_pc = m_pc + 8'd1;
        end
        2'b10:   ;
        default: m_pc = m_pc + 8'd1;
      endcase
    end
    @(negedge clk);
    if (op == 3'b111 && sub == 2'b10) begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || instr_req !== 1'b0 || pc !== m_pc) begin
        errors++;
        $display("FAIL halt_entry: done=%b busy=%b req=%b pc=%0d required 1 0 0 %0d",
                 done, busy, instr_req, pc, m_pc);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (instr_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pc !== 8'd0 ||
        alu_op !== 3'd0 || alu_a !== 8'd0 || alu_b !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: req=%b busy=%b done=%b pc=%0d op=%b a=%0d b=%0d required 0",
               instr_req, busy, done, pc, alu_op, alu_a, alu_b);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: req=%b busy=%b required 0 0", instr_req, busy);
    end
  endtask

  task automatic test_li_xor();
    do_start();
    run_instr(mk_sp(2'b01, 4'd5), 0, 1'b0);
    run_instr(mk_alu(3'b010, 2'd1, 2'd0, 2'd0), 1, 1'b0);
  endtask

  task automatic test_branch();
    run_instr(mk_sp(2'b00, 4'd3), 0, 1'b0);
    checks++;
    if (pc !== 8'd5) begin
      errors++;
      $display("FAIL bz_after_xor: pc=%0d required=5", pc);
    end
    while (m_pc != 8'd10) run_instr(mk_sp(2'b11, 4'd0), 0, 1'b0);
    run_instr(mk_sp(2'b00, 4'b1110), 0, 1'b0);
    checks++;
    if (pc !== 8'd8) begin
      errors++;
      $display("FAIL bz_taken: pc=%0d required=8", pc);
    end
    run_instr(mk_alu(3'b000, 2'd3, 2'd3, 2'd0), 0, 1'b0);
    run_instr(mk_sp(2'b11, 4'd0), 0, 1'b0);
    run_instr(mk_sp(2'b00, 4'b1110), 0, 1'b0);
    checks++;
    if (pc !== 8'd11) begin
      errors++;
      $display("FAIL bz_not_taken: pc=%0d required=11", pc);
    end
  endtask

  task automatic test_stall();
    start = 1'b1;
    run_instr(mk_alu(3'b100, 2'd2, 2'd0, 2'd3), 7, 1'b0);
    start = 1'b0;
  endtask

  task automatic test_random();
    logic [8:0] ins;
    logic [2:0] op;
    logic [1:0] sub;
    for (int k = 0; k < 60; k++) begin
      op = 3'($urandom_range(0, 7));
      ins = 9'($urandom);
      if (op == 3'b111) begin
        sub = 2'($urandom_range(0, 2));
        if (sub == 2'b10) sub = 2'b11;
        ins = mk_sp(sub, ins[3:0]);
      end else begin
        ins[8:6] = op;
      end
      run_instr(ins, $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_wrap();
    while (m_pc != 8'd255) run_instr(mk_sp(2'b11, 4'd0), 0, 1'b0);
    run_instr(mk_sp(2'b11, 4'd0), 0, 1'b0);
    checks++;
    if (pc !== 8'd0 || instr_req !== 1'b1) begin
      errors++;
      $display("FAIL pc_wrap: pc=%0d req=%b required 0 1", pc, instr_req);
    end
  endtask

  task automatic test_halt();
    run_instr(mk_alu(3'b001, 2'd1, 2'd2, 2'd0), 0, 1'b0);
    run_instr(mk_sp(2'b10, 4'd0), 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || pc !== m_pc) begin
        errors++;
        $display("FAIL halt_hold: done=%b busy=%b pc=%0d required 1 0 %0d", done, busy, pc, m_pc);
      end
    end
    do_start();
    checks++;
    if (instr_req !== 1'b1 || pc !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart: req=%b pc=%0d busy=%b done=%b required 1 0 1 0",
               instr_req, pc, busy, done);
    end
    run_instr(mk_alu(3'b100, 2'd0, 2'd1, 2'd2), 0, 1'b0);
    run_instr(mk_alu(3'b110, 2'd3, 2'd3, 2'd0), 2, 1'b0);
  endtask

  task automatic test_reset_wb();
    run_instr(mk_alu(3'b000, 2'd2, 2'd2, 2'd0), 0, 1'b1);
    checks++;
    if (instr_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pc !== 8'd0 ||
        alu_op !== 3'd0 || alu_a !== 8'd0 || alu_b !== 8'd0) begin
      errors++;
      $display("FAIL reset_in_wb: req=%b busy=%b done=%b pc=%0d op=%b a=%0d b=%0d required 0",
               instr_req, busy, done, pc, alu_op, alu_a, alu_b);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_abort: req=%b busy=%b required 0 0", instr_req, busy);
    end
    do_start();
    run_instr(mk_alu(3'b100, 2'd1, 2'd2, 2'd2), 0, 1'b0);
    run_instr(mk_alu(3'b101, 2'd0, 2'd3, 2'd1), 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_li_xor();
    test_branch();
    test_stall();
    test_random();
    test_wrap();
    test_halt();
    test_reset_wb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter AW, default 2, register-index width; register file has 2**AW entries.
REQ-002 Parameter DW, default 8, datapath width.
REQ-003 Parameter PW, default 8, program-counter width.
REQ-004 CLK  in  1  sole clock, all state on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse, begins execution at PC 0 when idle.
REQ-007 instr_req  out  1  instruction fetch request.
REQ-008 pc  out  PW  instruction address, stable while instr_req high.
REQ-009 instr_valid  in  1  instr_i valid; completes the fetch handshake.
REQ-010 instr_i  in  9  instruction word.
REQ-011 alu_op  out  3  ALU operation code, 000..110 as defined for the ALU.
REQ-012 alu_a  out  DW  ALU input1.
REQ-013 alu_b  out  DW  ALU input2.
REQ-014 alu_result  in  DW  combinational ALU Output.
REQ-015 alu_zero  in  1  combinational ALU Zero.
REQ-016 busy  out  1  high in every state except IDLE and HALT.
REQ-017 done  out  1  high while in HALT.

Function
REQ-018 Encoding: instr_i[8:6] opcode; opcodes 000..110 are ALU ops with rd=[5:4], rs=[3:2], rt=[1:0] (AW=2).
REQ-019 Opcode 111 is special; [5:4]=00 BZ (signed 4-bit offset [3:0]), 01 LI (r0 <= zero-extended [3:0]), 10 HALT, 11 NOP.
REQ-020 FSM states IDLE, FETCH, EXEC, WB, HALT; reset state IDLE.
REQ-021 IDLE -> FETCH on start; pc <= 0, zflag <= 0; start ignored in all other states except HALT, where it restarts identically.
REQ-022 FETCH: instr_req=1; on instr_valid, latch instr_i into ir, go EXEC; no timeout, stays in FETCH indefinitely.
REQ-023 EXEC (one cycle): for ALU ops drive alu_op=opcode, alu_a=reg[rs], alu_b=reg[rt]; go WB.
REQ-024 WB (one cycle): ALU op writes alu_result to reg[rd] and alu_zero to zflag, both captured from EXEC-cycle values.
REQ-025 Result and zero shall be registered at end of EXEC; WB shall not sample the ALU combinationally.
REQ-026 Ops 000, 001, 011 ignore alu_b; alu_b still drives reg[rt].
REQ-027 LI, NOP, BZ do not alter zflag; LI writes r0 in WB.
REQ-028 BZ: if zflag=1, pc <= pc + sign-extended offset, else pc <= pc+1; arithmetic modulo 2**PW.
REQ-029 All non-branch instructions: pc <= pc+1 in WB, wrap 2**PW-1 -> 0.
REQ-030 HALT opcode: go to HALT in WB, pc not incremented; done=1.
REQ-031 WB -> FETCH for all non-HALT instructions; ALU instruction latency = fetch wait + 3 cycles.
REQ-032 Outside EXEC, alu_op=000, alu_a=0, alu_b=0.
REQ-033 Write to rd and read of same register in the next instruction shall return the new value (no bypass needed; WB precedes next EXEC).

Reset
REQ-034 Reset forces IDLE, pc=0, ir=0, zflag=0, all registers 0, instr_req=0, busy=0, done=0, alu_op/alu_a/alu_b=0.
REQ-035 Reset asserted mid-fetch or mid-WB aborts immediately; no register write completes.

Structure
REQ-036 Shared package holds FSM state enum, opcode constants (ALU ops 000..110, SPECIAL=111), special sub-codes and instruction field positions.
REQ-037 Register file is one sub-module, regfile (2**AW x DW, two async read ports, one sync write port, async reset).
REQ-038 The ALU is instantiated outside this block; no ALU logic inside.

Verification
REQ-039 LI 5; XOR r1,r0,r0 -> alu_op=010, alu_a=alu_b=5, r1=0, zflag=1.
REQ-040 zflag=1, pc=10, BZ offset 1110 -> next pc=8; zflag=0 -> next pc=11.
REQ-041 pc=255 executing NOP -> next fetch at pc=0.
REQ-042 instr_valid held low 7 cycles in FETCH -> instr_req, pc stable, busy=1 throughout, no state change.
REQ-043 Reset pulsed during WB of INC r2 -> r2 remains 0, state IDLE, all outputs at reset values.
REQ-044 HALT -> done=1, busy=0, pc frozen; start -> pc=0, FETCH next cycle, registers retained.
